// File: rtl/rx_arp_analy_if.sv
// ARP body stream from the MAC-layer splitter.
// The splitter drives the master side and the parser takes the slave side.
interface rx_arp_analy_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] arp_data;
  logic              arp_vld;
  logic              arp_sop;
  logic              arp_eop;
  logic [1:0]        arp_mod;

  modport master (output arp_data, arp_vld, arp_sop, arp_eop, arp_mod);
  modport slave  (input  arp_data, arp_vld, arp_sop, arp_eop, arp_mod);
endinterface

// File: rtl/rx_arp_analy.sv
// Receive-side ARP parser: walks the 28-byte body and validates the fixed fields and target IP.
// For each packet it pulses exactly one of req/rply/err and publishes the sender of every accepted packet.
module rx_arp_analy #(
  parameter int DATA_W     = 32,
  parameter int MAC_ADDR_W = 48,
  parameter int IP_ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IP_ADDR_W-1:0]  cfg_ip_local,
  rx_arp_analy_if.slave         arp,
  output logic                  arp_req,
  output logic                  arp_rply,
  output logic                  arp_err,
  output logic [MAC_ADDR_W-1:0] src_mac,
  output logic [IP_ADDR_W-1:0]  src_ip
);

  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

  state_t                r_state;
  logic [2:0]            r_wcnt;
  logic [15:0]           r_htype;
  logic [15:0]           r_ptype;
  logic [7:0]            r_hlen;
  logic [7:0]            r_plen;
  logic [15:0]           r_oper;
  logic [MAC_ADDR_W-1:0] r_sha;
  logic [IP_ADDR_W-1:0]  r_spa;
  logic [IP_ADDR_W-1:0]  r_tpa;
  logic                  r_req;
  logic                  r_rply;
  logic                  r_err;
  logic [MAC_ADDR_W-1:0] r_src_mac;
  logic [IP_ADDR_W-1:0]  r_src_ip;

  logic [DATA_W-1:0]     w_data;
  logic                  w_fields_ok;
  logic                  w_tpa_ok;
  logic                  w_good;

  assign w_data = arp.arp_data;

  assign w_fields_ok = (r_htype == 16'h0001) && (r_ptype == 16'h0800) &&
                       (r_hlen == 8'd6) && (r_plen == 8'd4) &&
                       ((r_oper == 16'd1) || (r_oper == 16'd2));

  // When eop lands on w6 the TPA is still on the bus and must be complete;
  // in DRAIN it was already staged.
  assign w_tpa_ok = ((r_state == BODY) && (r_wcnt == 3'd6) &&
                     (w_data == cfg_ip_local) && (arp.arp_mod == 2'd0)) ||
                    ((r_state == DRAIN) && (r_tpa == cfg_ip_local));

  assign w_good = w_fields_ok && w_tpa_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wcnt    <= 3'd0;
      r_htype   <= '0;
      r_ptype   <= '0;
      r_hlen    <= '0;
      r_plen    <= '0;
      r_oper    <= '0;
      r_sha     <= '0;
      r_spa     <= '0;
      r_tpa     <= '0;
      r_req     <= 1'b0;
      r_rply    <= 1'b0;
      r_err     <= 1'b0;
      r_src_mac <= '0;
      r_src_ip  <= '0;
    end else begin
      r_req  <= 1'b0;
      r_rply <= 1'b0;
      r_err  <= 1'b0;
      if (arp.arp_vld) begin
        if (arp.arp_sop) begin
          // A sop always restarts parsing; one that interrupts a packet drops it.
          if (r_state != IDLE) r_err <= 1'b1;
          r_htype <= w_data[31:16];
          r_ptype <= w_data[15:0];
          if (arp.arp_eop) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_wcnt  <= 3'd0;
          end else begin
            r_state <= BODY;
            r_wcnt  <= 3'd1;
          end
        end else begin
          case (r_state)
            BODY: begin
              case (r_wcnt)
                3'd1: begin
                  r_hlen <= w_data[31:24];
                  r_plen <= w_data[23:16];
                  r_oper <= w_data[15:0];
                end
                3'd2: r_sha[47:16] <= w_data;
                3'd3: begin
                  r_sha[15:0]  <= w_data[31:16];
                  r_spa[31:16] <= w_data[15:0];
                end
                3'd4: r_spa[15:0] <= w_data[31:16];
                3'd6: r_tpa <= w_data;
                default: ;
              endcase
              if (arp.arp_eop) begin
                if (w_good) begin
                  r_req     <= (r_oper == 16'd1);
                  r_rply    <= (r_oper == 16'd2);
                  r_src_mac <= r_sha;
                  r_src_ip  <= r_spa;
                end else begin
                  r_err <= 1'b1;
                end
                r_state <= IDLE;
                r_wcnt  <= 3'd0;
              end else begin
                r_wcnt <= r_wcnt + 3'd1;
                if (r_wcnt == 3'd6) r_state <= DRAIN;
              end
            end
            DRAIN: begin
              if (arp.arp_eop) begin
                if (w_good) begin
                  r_req     <= (r_oper == 16'd1);
                  r_rply    <= (r_oper == 16'd2);
                  r_src_mac <= r_sha;
                  r_src_ip  <= r_spa;
                end else begin
                  r_err <= 1'b1;
                end
                r_state <= IDLE;
                r_wcnt  <= 3'd0;
              end else begin
                r_wcnt <= 3'd7;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign arp_req  = r_req;
  assign arp_rply = r_rply;
  assign arp_err  = r_err;
  assign src_mac  = r_src_mac;
  assign src_ip   = r_src_ip;

endmodule

// File: tb/tb_rx_arp_analy.sv
// Bench for rx_arp_analy: directed scenarios followed by random packets.
// The outputs are compared on every cycle against a model that judges each packet as a whole.
module tb_rx_arp_analy;

  localparam logic [31:0] CFG_IP = 32'hC0A80001;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_ip_local;
  logic        arp_req, arp_rply, arp_err;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  rx_arp_analy_if #(.DATA_W(32)) bus ();

  rx_arp_analy dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_ip_local (cfg_ip_local),
    .arp          (bus),
    .arp_req      (arp_req),
    .arp_rply     (arp_rply),
    .arp_err      (arp_err),
    .src_mac      (src_mac),
    .src_ip       (src_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the words of the packet in progress.
  logic [31:0] pkt_q[$];
  logic [31:0] tx_q[$];
  bit          in_pkt;
  logic        e_req, e_rply, e_err;
  logic [47:0] e_mac;
  logic [31:0] e_ip;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("arp_req",  64'(arp_req),  64'(e_req));
    check("arp_rply", 64'(arp_rply), 64'(e_rply));
    check("arp_err",  64'(arp_err),  64'(e_err));
    check("src_mac",  64'(src_mac),  64'(e_mac));
    check("src_ip",   64'(src_ip),   64'(e_ip));
  endtask

  // Judge a finished packet from its list of words.
  task automatic model_eval(input logic [1:0] mod);
    int n;
    bit ok;
    n  = pkt_q.size();
    ok = (n >= 7);
    if (ok) begin
      ok = (pkt_q[0] == 32'h00010800) && (pkt_q[1][31:16] == 16'h0604) &&
           (pkt_q[1][15:0] == 16'd1 || pkt_q[1][15:0] == 16'd2) &&
           (pkt_q[6] == cfg_ip_local) && !(n == 7 && mod != 2'd0);
    end
    if (ok) begin
      e_req  = (pkt_q[1][15:0] == 16'd1);
      e_rply = (pkt_q[1][15:0] == 16'd2);
      e_mac  = {pkt_q[2], pkt_q[3][31:16]};
      e_ip   = {pkt_q[3][15:0], pkt_q[4][31:16]};
    end else begin
      e_err = 1'b1;
    end
  endtask

  task automatic model_beat(input logic v, input logic s, input logic e,
                            input logic [1:0] m, input logic [31:0] d);
    e_req = 1'b0; e_rply = 1'b0; e_err = 1'b0;
    if (v) begin
      if (s) begin
        if (in_pkt) e_err = 1'b1;
        pkt_q.delete();
        pkt_q.push_back(d);
        in_pkt = 1'b1;
        if (e) begin
          e_err  = 1'b1;
          in_pkt = 1'b0;
        end
      end else if (in_pkt) begin
        pkt_q.push_back(d);
        if (e) begin
          model_eval(m);
          in_pkt = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e,
                      input logic [1:0] m, input logic [31:0] d);
    bus.arp_vld  = v;
    bus.arp_sop  = s;
    bus.arp_eop  = e;
    bus.arp_mod  = m;
    bus.arp_data = d;
    model_beat(v, s, e, m, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    logic [31:0] j;
    j = $urandom;
    step(1'b0, j[0], j[1], j[3:2], $urandom);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.arp_vld  = 1'b0;
    in_pkt       = 1'b0;
    pkt_q.delete();
    e_req = 1'b0; e_rply = 1'b0; e_err = 1'b0;
    e_mac = '0;   e_ip = '0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic build_pkt(input logic [15:0] htype, input logic [15:0] ptype,
                           input logic [7:0] hlen, input logic [7:0] plen,
                           input logic [15:0] oper, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [31:0] tpa, input int npad);
    logic [47:0] tha;
    tha = {16'($urandom), 32'($urandom)};
    tx_q.delete();
    tx_q.push_back({htype, ptype});
    tx_q.push_back({hlen, plen, oper});
    tx_q.push_back(sha[47:16]);
    tx_q.push_back({sha[15:0], spa[31:16]});
    tx_q.push_back({spa[15:0], tha[47:32]});
    tx_q.push_back(tha[31:0]);
    tx_q.push_back(tpa);
    for (int i = 0; i < npad; i++) tx_q.push_back($urandom);
  endtask

  task automatic good_pkt(input logic [15:0] oper, input logic [47:0] sha,
                          input logic [31:0] spa, input int npad);
    build_pkt(16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, CFG_IP, npad);
  endtask

  // Send words first..last of tx_q with optional vld gaps before each word.
  task automatic send_range(input int first, input int last, input bit eop_at_last,
                            input logic [1:0] mod, input int gap_pct);
    logic [31:0] j;
    for (int i = first; i <= last; i++) begin
      for (int g = 0; g < 2; g++)
        if ($urandom_range(0, 99) < gap_pct) idle_step();
      j = $urandom;
      step(1'b1, i == 0, eop_at_last && (i == last), (i == last) ? mod : j[1:0], tx_q[i]);
    end
  endtask

  task automatic send_all(input logic [1:0] mod, input int gap_pct);
    send_range(0, tx_q.size() - 1, 1'b1, mod, gap_pct);
  endtask

  initial begin
    logic [31:0] a, b, c;
    logic [15:0] htype, ptype, oper;
    logic [7:0]  hlen, plen, x;
    logic [31:0] tpa;
    logic [1:0]  mod;
    int          kind, npad, last;

    cfg_ip_local = CFG_IP;
    bus.arp_vld = 1'b0; bus.arp_sop = 1'b0; bus.arp_eop = 1'b0;
    bus.arp_mod = 2'd0; bus.arp_data = '0;
    rst_n = 1'b1;
    #2;
    do_reset();
    idle_step();

    good_pkt(16'd1, 48'h001122334455, 32'hC0A80002, 0);
    send_all(2'd0, 0);
    $display("dir request exact: req=%0b mac=%h ip=%h", arp_req, src_mac, src_ip);
    idle_step();

    good_pkt(16'd2, 48'hA0B0C0D0E0F0, 32'hC0A80003, 4);
    send_all(2'd2, 0);
    $display("dir reply padded: rply=%0b mac=%h ip=%h", arp_rply, src_mac, src_ip);
    idle_step();

    build_pkt(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h665544332211, 32'hC0A80004, 32'hC0A80009, 0);
    send_all(2'd0, 0);
    $display("dir wrong target: err=%0b", arp_err);
    idle_step();

    good_pkt(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80005, 0);
    send_range(0, 4, 1'b1, 2'd0, 0);
    $display("dir short packet: err=%0b", arp_err);
    build_pkt(16'h0001, 16'h86DD, 8'd6, 8'd4, 16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80005, CFG_IP, 0);
    send_all(2'd0, 0);
    $display("dir bad ptype: err=%0b", arp_err);

    good_pkt(16'd1, 48'h111111111111, 32'hC0A80011, 1);
    send_all(2'd1, 60);
    $display("dir back-to-back #1: req=%0b ip=%h", arp_req, src_ip);
    good_pkt(16'd1, 48'h222222222222, 32'hC0A80022, 0);
    send_all(2'd0, 0);
    $display("dir back-to-back #2: req=%0b ip=%h", arp_req, src_ip);

    good_pkt(16'd2, 48'h333333333333, 32'hC0A80033, 0);
    send_range(0, 2, 1'b0, 2'd0, 0);
    good_pkt(16'd2, 48'h444444444444, 32'hC0A80044, 0);
    send_all(2'd0, 0);
    $display("dir abort then reply: rply=%0b ip=%h", arp_rply, src_ip);

    good_pkt(16'd1, 48'h555555555555, 32'hC0A80055, 0);
    send_range(0, 1, 1'b0, 2'd0, 0);
    do_reset();
    send_range(2, 6, 1'b1, 2'd0, 0);
    good_pkt(16'd1, 48'h666666666666, 32'hC0A80066, 0);
    send_all(2'd0, 0);
    $display("dir reset mid-packet then request: req=%0b ip=%h", arp_req, src_ip);

    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      a = $urandom; b = $urandom; c = $urandom;
      htype = 16'h0001; ptype = 16'h0800; hlen = 8'd6; plen = 8'd4;
      oper = a[31] ? 16'd1 : 16'd2;
      tpa  = CFG_IP;
      npad = $urandom_range(0, 4);
      mod  = (npad == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      last = -1;
      case (kind)
        0: htype = 16'h0001 ^ (a[15:0] | 16'h0001);
        1: ptype = 16'h0800 ^ (a[15:0] | 16'h0001);
        2: begin
          x = a[8:1] | 8'd1;
          if (a[0]) hlen = 8'd6 ^ x; else plen = 8'd4 ^ x;
        end
        3: oper = a[0] ? 16'd0 : 16'd3;
        4: tpa = CFG_IP ^ (c | 32'd1);
        5: last = $urandom_range(0, 5);
        6: begin npad = 0; mod = 2'($urandom_range(1, 3)); end
        default: ;
      endcase
      build_pkt(htype, ptype, hlen, plen, oper, {a[15:0], b}, c, tpa, npad);
      if (kind == 7)
        send_range(0, $urandom_range(1, 6), 1'b0, 2'd0, 20);
      else if (last >= 0)
        send_range(0, last, 1'b1, mod, 20);
      else
        send_all(mod, 20);
      $display("rnd pkt %0d kind %0d: req=%0b rply=%0b err=%0b", p, kind, arp_req, arp_rply, arp_err);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_step();
    end

    idle_step();
    idle_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
